// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - request/data/grant bundle between requesters and the round-robin mux arbiter
//
// Signals:
//   req  [7:0]  requester -> arbiter, level-held request lines
//   D    [7:0]  requester -> arbiter, mux data inputs (D[i] belongs to requester i)
//   S    [2:0]  arbiter -> mux, registered select (index of current grantee)
//   gnt  [7:0]  arbiter -> requester, registered one-hot grant
//   busy        arbiter -> requester, registered, high while a grant is active
//   Y           arbiter -> consumer, D[S] while busy, else 0
// Modports: master (requester/consumer side), slave (arbiter side).

interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] D;
    logic [2:0] S;
    logic [7:0] gnt;
    logic       busy;
    logic       Y;

    modport master (
        output req,
        output D,
        input  S,
        input  gnt,
        input  busy,
        input  Y
    );

    modport slave (
        input  req,
        input  D,
        output S,
        output gnt,
        output busy,
        output Y
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter owning the select of an 8:1 single-bit mux
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles when the hold limit is built in (1..255)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mux8_rr_arbiter_if.slave: req/D in, S/gnt/busy (registered) and Y (combinational) out
// Build option:
//   RR_HOLD_LIMIT_EN  when defined, a grant is forcibly released after HOLD_MAX cycles
//                     and the pointer moves past the preempted requester.

module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mux8_rr_arbiter_if.slave         bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [2:0] s_nxt;
    logic [7:0] gnt_nxt;
    logic       busy_nxt;
    logic [2:0] winner;
    logic       hold_hit;
    logic       release_grant;

    // First set request scanning upward from p, wrapping modulo 8.
    // Iterating from the far end down lets the nearest hit overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        rr_pick = p;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign winner   = rr_pick(bus.req, ptr);
    assign hold_hit = (cnt == CNT_LAST);

`ifdef RR_HOLD_LIMIT_EN
    assign release_grant = !bus.req[bus.S] || hold_hit;
`else
    assign release_grant = !bus.req[bus.S];
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            cnt      <= 8'd0;
            bus.S    <= 3'd0;
            bus.gnt  <= 8'd0;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            bus.S    <= s_nxt;
            bus.gnt  <= gnt_nxt;
            bus.busy <= busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req != 8'd0) state_nxt = GRANT;
            GRANT:   if (release_grant)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        ptr_nxt  = ptr;
        cnt_nxt  = cnt;
        s_nxt    = bus.S;
        gnt_nxt  = bus.gnt;
        busy_nxt = bus.busy;
        case (state)
            IDLE: begin
                if (bus.req != 8'd0) begin
                    s_nxt    = winner;
                    gnt_nxt  = 8'd1 << winner;
                    busy_nxt = 1'b1;
                    cnt_nxt  = 8'd0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    // S keeps the old grantee so the mux select stays stable while idle
                    gnt_nxt  = 8'd0;
                    busy_nxt = 1'b0;
                    ptr_nxt  = bus.S + 3'd1;
                end else if (!hold_hit) begin
                    // Saturates so a limit-free build never wraps the counter
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                gnt_nxt  = 8'd0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    assign bus.Y = bus.busy ? bus.D[bus.S] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - self-checking bench for mux8_rr_arbiter

module tb_mux8_rr_arbiter;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] d;
        logic [7:0] gnt;
        logic [2:0] s;
        logic       busy;
        logic       y;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs[$];

    mux8_rr_arbiter_if bus ();

    mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] es,
                             input logic eb, input logic ey);
        cmp({tag, ".gnt"}, bus.gnt, eg);
        cmp({tag, ".S"}, {5'd0, bus.S}, {5'd0, es});
        cmp({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, eb});
        cmp({tag, ".Y"}, {7'd0, bus.Y}, {7'd0, ey});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req = 8'h00;
        bus.D = 8'hAA;

        //            rst   req    D      gnt    S     busy  Y
        vecs.push_back('{1'b1, 8'hFF, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0}); // reset under load
        vecs.push_back('{1'b1, 8'hFF, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hFF, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0}); // idle
        vecs.push_back('{1'b0, 8'h20, 8'hAA, 8'h20, 3'd5, 1'b1, 1'b1}); // single requester 5
        vecs.push_back('{1'b0, 8'h20, 8'hAA, 8'h20, 3'd5, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 8'h20, 8'hAA, 8'h20, 3'd5, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 8'hAA, 8'h00, 3'd5, 1'b0, 1'b0}); // release, ptr=6
        vecs.push_back('{1'b0, 8'h40, 8'hAA, 8'h40, 3'd6, 1'b1, 1'b0}); // grant 6
        vecs.push_back('{1'b0, 8'h00, 8'hAA, 8'h00, 3'd6, 1'b0, 1'b0}); // release, ptr=7
        vecs.push_back('{1'b0, 8'h03, 8'h55, 8'h01, 3'd0, 1'b1, 1'b1}); // wrap to 0
        vecs.push_back('{1'b0, 8'h00, 8'h55, 8'h00, 3'd0, 1'b0, 1'b0}); // ptr=1
        vecs.push_back('{1'b0, 8'h08, 8'hAA, 8'h08, 3'd3, 1'b1, 1'b1}); // grant 3
        vecs.push_back('{1'b1, 8'h08, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0}); // reset mid-grant
        vecs.push_back('{1'b0, 8'hFF, 8'hAA, 8'h01, 3'd0, 1'b1, 1'b0}); // ptr back at 0
        vecs.push_back('{1'b0, 8'hFE, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0}); // release + new req same edge
        vecs.push_back('{1'b0, 8'hFE, 8'hAA, 8'h02, 3'd1, 1'b1, 1'b1}); // new req seen after idle
        vecs.push_back('{1'b0, 8'h06, 8'hAA, 8'h02, 3'd1, 1'b1, 1'b1}); // other bits ignored
        vecs.push_back('{1'b0, 8'h00, 8'hAA, 8'h00, 3'd1, 1'b0, 1'b0}); // release, ptr=2
        vecs.push_back('{1'b0, 8'h00, 8'hAA, 8'h00, 3'd1, 1'b0, 1'b0}); // idle holds S

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            bus.req = vecs[i].req;
            bus.D   = vecs[i].d;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].busy, vecs[i].y);
        end

        // Y follows D combinationally while busy
        bus.req = 8'h04;
        tick();
        check_out("ycomb.grant", 8'h04, 3'd2, 1'b1, 1'b0);
        bus.D = 8'h04;
        #1;
        cmp("ycomb.rise", {7'd0, bus.Y}, 8'd1);
        bus.D = 8'hFB;
        #1;
        cmp("ycomb.fall", {7'd0, bus.Y}, 8'd0);
        bus.D = 8'hAA;
        bus.req = 8'h00;
        tick();
        check_out("ycomb.rel", 8'h00, 3'd2, 1'b0, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
        // Full-load rotation: 4-cycle grants, one idle cycle between
        bus.req = 8'hFF;
        for (int r = 0; r < 9; r++) begin
            logic [2:0] g;
            g = 3'(r % 8);
            for (int c = 0; c < 4; c++) begin
                tick();
                check_out($sformatf("rot%0d.c%0d", r, c), 8'd1 << g, g, 1'b1, g[0]);
            end
            tick();
            check_out($sformatf("rot%0d.idle", r), 8'h00, g, 1'b0, 1'b0);
        end
`else
        // No hold limit: requester 2 keeps the grant while req[2] stays high
        bus.req = 8'h0C;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_out($sformatf("nolim.c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
        end
        bus.req = 8'h08;
        tick();
        check_out("nolim.rel", 8'h00, 3'd2, 1'b0, 1'b0);
        tick();
        check_out("nolim.next", 8'h08, 3'd3, 1'b1, 1'b1);
`endif
        bus.req = 8'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin scheduler that shares the 8:1 single-bit mux datapath among eight requesters. Each requester asserts a request line; the block picks one winner, drives the mux select, and presents the selected data bit on its output. It holds the grant until the requester releases it, with an optional cycle limit. It sits in front of `mux8to1` and is the only driver of that mux's `S` input.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grant cycles when the hold limit is compiled in; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines; `req[i]` from requester i, level-held.
- `D`  in  8  mux data inputs; `D[i]` belongs to requester i.
- `S`  out  3  registered mux select, equal to the index of the current grantee.
- `gnt`  out  8  registered one-hot grant; all zero when idle.
- `busy`  out  1  registered; high while a grant is active.
- `Y`  out  1  combinational: `D[S]` when `busy`, else 0.

## Operation
- State machine has two states, IDLE and GRANT. It holds a 3-bit round-robin pointer `ptr` and an 8-bit hold counter `cnt`.
- **IDLE:**
  - If `req != 0`, the winner is the first set bit scanning `ptr, ptr+1, ..., 7, 0, ..., ptr-1` (mod 8).
  - Next edge: `S` = winner, `gnt` = one-hot(winner), `busy` = 1, `cnt` = 0, go to GRANT.
  - If `req == 0`, stay in IDLE; all outputs hold their idle values.
- **GRANT:**
  - Release condition: `req[S] == 0`, or (with the macro) `cnt == HOLD_MAX-1`.
  - On release, next edge: `gnt` = 0, `busy` = 0, `ptr` = `S+1` (7 wraps to 0), go to IDLE. `S` keeps its last value.
  - Otherwise `cnt` increments and the grant holds.
- Every release is followed by exactly one IDLE cycle before the next grant. No back-to-back grants.
- Changes on `req` bits other than the grantee's have no effect during GRANT.
- `Y` follows `D` combinationally while `busy` is high.
- **Reset values:** `S` = 0, `gnt` = 0, `busy` = 0, `Y` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
- Reset has priority over every other event, including reset asserted mid-grant.

## Timing
- **Grant latency:** `req` sampled high at edge N in IDLE gives `gnt`/`busy`/`S` valid after edge N.
- **Release latency:** `req[S]` sampled low at edge N in GRANT gives `gnt` = 0 after edge N.
- **Minimum grant length:** 1 cycle.
- **Maximum grant length with the macro:** exactly `HOLD_MAX` cycles of `busy` high.
- **Fairness under continuous full load (`req` = 8'hFF, macro on):** requester i waits at most 7×(`HOLD_MAX`+1) cycles.
- **Simultaneous events:**
  - Release and a new request on the same edge: the new request is only considered in the following IDLE cycle.
  - Reset and request on the same edge: reset wins.

## Configuration
- Macro: `RR_HOLD_LIMIT_EN`.
- **Defined:** `cnt` is active. A grant is forcibly released after `HOLD_MAX` cycles even if `req[S]` stays high. The pointer advances past the preempted requester.
- **Undefined:** no hold limit. `cnt` and `HOLD_MAX` are unused, and a grant lasts until `req[S]` drops.

## Test plan
- **Reset with load:** `rst` = 1, `req` = 8'hFF for 3 cycles → `gnt` = 0, `S` = 0, `busy` = 0, `Y` = 0 throughout.
- **Single requester:** `D` = 8'b10101010, `req` = 8'b0010_0000 for 3 cycles then 0.
  - One cycle after assertion: `gnt` = 8'b0010_0000, `S` = 5, `Y` = 1, held 3 cycles.
  - `gnt` = 0 the cycle after `req` drops.
- **Rotation under full load:** macro on, `HOLD_MAX` = 4, `req` = 8'hFF → grants go 0, 1, 2, ..., 7, 0. Each lasts 4 cycles, separated by 1 idle cycle. `Y` alternates 0/1 per grant with the `D` above.
- **Pointer wrap:** grant 6 then release (`ptr` = 7), then `req` = 8'b0000_0011 → next `gnt` = 8'b0000_0001, `S` = 0.
- **Reset mid-grant:** `rst` pulsed during a grant to requester 3 → next edge `gnt` = 0, `S` = 0, `busy` = 0. With `req` = 8'hFF afterwards, the first grant goes to requester 0.
- **No limit:** macro off, `req` = 8'b0000_1100 held 20 cycles → `gnt` = 8'b0000_0100 for all 20 cycles. Requester 3 is granted only after `req[2]` drops plus one idle cycle.
